dma_io_agent: RTL

- Peripheral-side endpoint of the four-channel DMA controller's dreq/dack handshake; one instance sits on each I/O device attached to a DMA channel.
- Buffers device data in two FIFOs: outbound (device->memory) and inbound (memory->device).
- Raises dreq in demand mode and moves one byte per DMA transfer strobe while dack is high.
- Drives eop on the final byte of a programmed count and honours early eop from the controller.

---
 rtl/dma_io_agent.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_io_agent.sv
// dma_io_agent
// Peripheral-side endpoint of a DMA dreq/dack handshake. Device data is
// buffered in two FIFOs: outbound (device -> memory) and inbound
// (memory -> device). When a transfer is armed, dreq is raised. One byte
// moves per xfer_stb while dack is high. eop_out marks the final byte, and
// an early eop_in from the controller ends the transfer and keeps the
// untransferred residue in 'remaining'.
//
// Optional feature (macro DMA_BURST_HOLD_EN): dreq is only raised from REQ
// once a worthwhile burst is available. For outbound, that means
// level >= DEPTH/2 or level >= remaining. For inbound, the same test is
// applied to the free entries. Once raised, dreq holds until the FIFO
// runs dry (or fills) or the count is exhausted.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start, dir, count       arm a transfer (dir 0 = dev->mem, 1 = mem->dev)
//   dev_wr_valid/data/ready device push into the outbound FIFO
//   dev_rd_valid/data/ready device pull from the inbound FIFO
//   dreq, dack, xfer_stb    DMA handshake and per-byte strobe
//   bus_data_in             memory-side data for dir=1
//   bus_data_out, _oe       outbound head driven toward memory
//   eop_in, eop_out         early terminate in / final-byte indicator out
//   busy, done, err         status (done is a pulse, err is sticky)
//   remaining               bytes still to move

module dma_io_agent #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dir,
    input  logic [CNT_W-1:0]  count,
    input  logic              dev_wr_valid,
    input  logic [DATA_W-1:0] dev_wr_data,
    output logic              dev_wr_ready,
    output logic              dev_rd_valid,
    output logic [DATA_W-1:0] dev_rd_data,
    input  logic              dev_rd_ready,
    output logic              dreq,
    input  logic              dack,
    input  logic              xfer_stb,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    input  logic              eop_in,
    output logic              eop_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  remaining
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
`ifdef DMA_BURST_HOLD_EN
    localparam logic [AW:0]      HALF_LVL = (AW+1)'(DEPTH/2);
`endif

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t            state, state_next;
    logic              dir_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              err_q;
    logic              dreq_q, dreq_d;

    logic [DATA_W-1:0] ob_mem [DEPTH];
    logic [AW-1:0]     ob_rd, ob_wr;
    logic [AW:0]       ob_level;
    logic [DATA_W-1:0] ib_mem [DEPTH];
    logic [AW-1:0]     ib_rd, ib_wr;
    logic [AW:0]       ib_level;

    logic ob_empty, ob_full, ib_empty, ib_full;
    logic ob_push, ob_pop, ib_push, ib_pop;
    logic byte_stb, byte_moved, byte_fault;
    logic active_next, dir_eff, rem_nz, dreq_cond;
    logic [CNT_W-1:0] rem_eff;
    logic [AW:0]      ib_free, level_eff;

    assign ob_empty = (ob_level == '0);
    assign ob_full  = (ob_level == FULL_LVL);
    assign ib_empty = (ib_level == '0);
    assign ib_full  = (ib_level == FULL_LVL);
    assign ib_free  = FULL_LVL - ib_level;

    // A strobe only counts in XFER with dack high. It then either moves a
    // byte or, if the FIFO on the memory side cannot take or give one,
    // flags an underrun or overrun and leaves everything else untouched.
    assign byte_stb   = (state == XFER) & dack & xfer_stb;
    assign ob_push    = dev_wr_valid & ~ob_full;
    assign ob_pop     = byte_stb & ~dir_q & ~ob_empty;
    assign ib_push    = byte_stb & dir_q & ~ib_full;
    assign ib_pop     = dev_rd_ready & ~ib_empty;
    assign byte_moved = ob_pop | ib_push;
    assign byte_fault = byte_stb & (dir_q ? ib_full : ob_empty);

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (count == '0) ? DONE : REQ;
            REQ: begin
                if (eop_in)    state_next = DONE;
                else if (dack) state_next = XFER;
            end
            XFER: begin
                if (eop_in || (byte_moved && remaining_q == CNT_ONE)) state_next = DONE;
                else if (!dack)                                       state_next = REQ;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // dreq is registered, so it follows FIFO levels one cycle late. While
    // a start is being accepted, dir_q and remaining_q are not loaded yet,
    // so the request condition looks at the incoming dir/count instead.
    always_comb begin
        active_next = (state_next == REQ) || (state_next == XFER);
        dir_eff     = (state == IDLE) ? dir : dir_q;
        rem_eff     = (state == IDLE) ? count : remaining_q;
        level_eff   = dir_eff ? ib_free : ob_level;
        rem_nz      = (rem_eff != '0);
`ifdef DMA_BURST_HOLD_EN
        dreq_cond   = (dreq_q & (level_eff != '0) & rem_nz)
                    | ((state == REQ) & rem_nz &
                       ((level_eff >= HALF_LVL) || (32'(level_eff) >= 32'(rem_eff))));
`else
        dreq_cond   = (level_eff != '0) & rem_nz;
`endif
        dreq_d      = active_next & dreq_cond;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            dreq_q      <= 1'b0;
            ob_rd       <= '0;
            ob_wr       <= '0;
            ob_level    <= '0;
            ib_rd       <= '0;
            ib_wr       <= '0;
            ib_level    <= '0;
        end else begin
            state  <= state_next;
            dreq_q <= dreq_d;

            if (state == IDLE && start) begin
                dir_q       <= dir;
                remaining_q <= count;
                err_q       <= 1'b0;
            end else begin
                if (byte_moved) remaining_q <= remaining_q - CNT_ONE;
                if (byte_fault) err_q       <= 1'b1;
            end

            if (ob_push) ob_wr <= ob_wr + PTR_ONE;
            if (ob_pop)  ob_rd <= ob_rd + PTR_ONE;
            case ({ob_push, ob_pop})
                2'b10:   ob_level <= ob_level + LVL_ONE;
                2'b01:   ob_level <= ob_level - LVL_ONE;
                default: ob_level <= ob_level;
            endcase

            if (ib_push) ib_wr <= ib_wr + PTR_ONE;
            if (ib_pop)  ib_rd <= ib_rd + PTR_ONE;
            case ({ib_push, ib_pop})
                2'b10:   ib_level <= ib_level + LVL_ONE;
                2'b01:   ib_level <= ib_level - LVL_ONE;
                default: ib_level <= ib_level;
            endcase
        end
    end

    // Storage needs no reset. The levels decide what is valid.
    always_ff @(posedge clk) begin
        if (ob_push) ob_mem[ob_wr] <= dev_wr_data;
        if (ib_push) ib_mem[ib_wr] <= bus_data_in;
    end

    assign dreq         = dreq_q;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign err          = err_q;
    assign remaining    = remaining_q;
    assign eop_out      = (state == XFER) & dack & (remaining_q == CNT_ONE);
    assign bus_data_oe  = dack & (state == XFER) & ~dir_q;
    assign bus_data_out = (bus_data_oe & ~ob_empty) ? ob_mem[ob_rd] : '0;
    assign dev_wr_ready = ~ob_full;
    assign dev_rd_valid = ~ib_empty;
    assign dev_rd_data  = ib_empty ? '0 : ib_mem[ib_rd];

endmodule
